up_down_count_monitor: RTL and testbench
========================================

Name: up_down_count_monitor

Overview:
- Passive observer for the up-down counter's count output; samples a WIDTH-bit count every clock.
- Decodes motion (running/holding, up/down), counts wrap-around events, pulses on direction reversal and flags illegal steps (any change other than +1/-1 modulo 2^WIDTH).
- Sits beside a counter instance in counter/timer subsystems and benches as a decoder/checker; drives nothing back into the counter.

Parameters:
- WIDTH, 4, width of observed count.
- WRAP_WIDTH, 8, width of saturating wrap-event counter.

Ports:
- Clk_In  input  1  clock; all state updates on rising edge.
- Reset_In  input  1  asynchronous, active-high reset.
- Enable_In  input  1  1 = sample Count_In this edge; 0 = freeze outputs, force resync.
- Count_In  input  WIDTH  observed count value.
- Clear_Error_In  input  1  synchronous clear of sticky error.
- Running_Out  output  1  1 = last enabled sample moved by +/-1.
- Up_Downb_Out  output  1  last detected direction of motion, 1 = up, 0 = down.
- Dir_Change_Out  output  1  one-cycle pulse when detected direction flips.
- Wrap_Count_Out  output  WRAP_WIDTH  number of wrap events, saturating at all-ones.
- Error_Out  output  1  sticky flag for illegal step.

Behaviour:
- Reset (async, any time, including mid-operation): state=S_INIT, prev=0, Running_Out=0, Up_Downb_Out=1, Dir_Change_Out=0, Wrap_Count_Out=0, Error_Out=0.
- Registers: prev (WIDTH), state in {S_INIT, S_HOLD, S_UP, S_DOWN}.
- All outputs registered. A value presented on Count_In before edge k is reflected on the outputs immediately after edge k.
- Enable_In=0 at an edge:
  - state -> S_INIT; prev unchanged.
  - Running_Out -> 0; Dir_Change_Out -> 0.
  - Up_Downb_Out, Wrap_Count_Out and Error_Out hold. Clear_Error_In is still honoured.
- Enable_In=1, state=S_INIT: prev <= Count_In; state -> S_HOLD; Running_Out=0; Dir_Change_Out=0; no error or wrap evaluation.
- Enable_In=1, other states: delta = (Count_In - prev) mod 2^WIDTH; prev <= Count_In always.
  - delta=0: state -> S_HOLD; Running_Out=0; direction holds.
  - delta=1: state -> S_UP; Running_Out=1; Up_Downb_Out=1. Wrap event if prev = 2^WIDTH-1 and Count_In = 0.
  - delta=2^WIDTH-1: state -> S_DOWN; Running_Out=1; Up_Downb_Out=0. Wrap event if prev = 0 and Count_In = 2^WIDTH-1.
  - Any other delta: Error_Out <= 1; state -> S_HOLD; Running_Out=0; direction holds; no wrap event.
- Dir_Change_Out=1 for exactly one cycle when a +1 or -1 step sets Up_Downb_Out to the opposite of its current value.
  - Intervening S_HOLD samples do not suppress the pulse; comparison is against the last movement direction.
  - The first movement after reset does not pulse if it is up.
- Wrap event: Wrap_Count_Out increments by 1, saturating at 2^WRAP_WIDTH-1.
- Error precedence: Error_Out is cleared by Clear_Error_In=1 at an edge, except that a new illegal step at the same edge wins and the flag stays 1.
- WIDTH=1: delta 1 and -1 coincide. Treat every change as up; every change is also a wrap.

Test Plan:
- Reset, Enable_In=1, count 0,1,...,15,0,1 -> Running_Out=1 and Up_Downb_Out=1 from the second sample onward; Wrap_Count_Out=1 after the 15->0 sample; Error_Out=0; Dir_Change_Out never pulses.
- Count 3,2,1,0,15,14 -> Up_Downb_Out=0 after the 3->2 sample, with a Dir_Change_Out pulse for one cycle; Wrap_Count_Out increments after 0->15.
- Count 5,5,5,6 -> Running_Out=0 for both 5->5 samples, 1 after 5->6; direction unchanged; no error.
- Count 3 then 7 -> Error_Out=1 after the jump and stays 1 through later legal steps. Clear_Error_In=1 for one edge -> 0. Repeat with Clear_Error_In=1 on the jump edge itself -> Error_Out=1.
- Enable_In=0 while count goes 4 -> 9, then Enable_In=1 with 9,10 -> no error; first enabled sample only recaptures; Running_Out=1 after the 9->10 sample.
- Assert Reset_In mid-edge-period during an up run with Wrap_Count_Out=2 and Error_Out=1 -> all outputs reach reset values immediately without waiting for a clock edge; the first sample after release does not raise an error.
- Wrap saturation (WRAP_WIDTH=2): 5 up-wraps -> Wrap_Count_Out stays at 3.

Source files
------------

// File: rtl/up_down_count_monitor.sv
// up_down_count_monitor: passive decoder/checker for an up-down counter output;
// reports motion, direction reversals, saturating wrap count and sticky illegal-step error.
module up_down_count_monitor #(
   parameter int WIDTH      = 4,
   parameter int WRAP_WIDTH = 8
) (
   input  logic                  Clk_In,
   input  logic                  Reset_In,
   input  logic                  Enable_In,
   input  logic [WIDTH-1:0]      Count_In,
   input  logic                  Clear_Error_In,
   output logic                  Running_Out,
   output logic                  Up_Downb_Out,
   output logic                  Dir_Change_Out,
   output logic [WRAP_WIDTH-1:0] Wrap_Count_Out,
   output logic                  Error_Out
);
   typedef enum logic [1:0] {S_INIT, S_HOLD, S_UP, S_DOWN} state_t;
   state_t                state, state_n;
   logic [WIDTH-1:0]      prev, delta;
   logic                  tracking, step_up, step_down, illegal, wrap_ev;
   logic                  running_n, up_n, dir_n, err_n;
   logic [WRAP_WIDTH-1:0] wrap_n;
   // With WIDTH=1 +1 and -1 coincide, so every change is classed as up and as a wrap.
   always_comb begin
      delta     = Count_In - prev;
      tracking  = Enable_In && state != S_INIT;
      step_up   = tracking && ((WIDTH == 1) ? delta != '0 : delta == WIDTH'(1));
      step_down = tracking && !step_up && delta == '1;
      illegal   = tracking && delta != '0 && !step_up && !step_down;
      wrap_ev   = (step_up && ((WIDTH == 1) || (prev == '1 && Count_In == '0))) ||
                  (step_down && prev == '0 && Count_In == '1);
   end
   always_comb begin
      state_n = !Enable_In ? S_INIT : step_up ? S_UP : step_down ? S_DOWN : S_HOLD;
   end
   always_comb begin
      running_n = step_up || step_down;
      up_n      = step_up ? 1'b1 : step_down ? 1'b0 : Up_Downb_Out;
      dir_n     = running_n && up_n != Up_Downb_Out;
      wrap_n    = (wrap_ev && Wrap_Count_Out != '1) ? Wrap_Count_Out + WRAP_WIDTH'(1) : Wrap_Count_Out;
      err_n     = illegal || (Error_Out && !Clear_Error_In);
   end
   always_ff @(posedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         state          <= S_INIT;
         prev           <= '0;
         Running_Out    <= 1'b0;
         Up_Downb_Out   <= 1'b1;
         Dir_Change_Out <= 1'b0;
         Wrap_Count_Out <= '0;
         Error_Out      <= 1'b0;
      end else begin
         state          <= state_n;
         if (Enable_In) prev <= Count_In;
         Running_Out    <= running_n;
         Up_Downb_Out   <= up_n;
         Dir_Change_Out <= dir_n;
         Wrap_Count_Out <= wrap_n;
         Error_Out      <= err_n;
      end
   end
endmodule

// File: tb/tb_up_down_count_monitor.sv
// tb_up_down_count_monitor: scoreboard bench; a behavioural model pushes expected outputs
// as each sample is driven, and each test pops and compares after the sampling edge.
module tb_up_down_count_monitor;
   logic       clk = 1'b0;
   logic       rst, en, clr;
   logic [3:0] cnt;
   logic       running, updown, dir, err;
   logic [7:0] wrap;
   logic       rst2, en2, clr2;
   logic [3:0] cnt2;
   logic       running2, updown2, dir2, err2;
   logic [1:0] wrap2;
   int         n_checks = 0;
   int         n_fail = 0;
   logic [11:0] exp_q[$];
   logic [11:0] got, expv;
   bit          m_sync;
   logic [3:0]  m_prev;
   logic        m_run, m_up, m_dir, m_err;
   logic [7:0]  m_wrap;

   always #5 clk = ~clk;

   up_down_count_monitor #(.WIDTH(4), .WRAP_WIDTH(8)) dut (
      .Clk_In(clk), .Reset_In(rst), .Enable_In(en), .Count_In(cnt), .Clear_Error_In(clr),
      .Running_Out(running), .Up_Downb_Out(updown), .Dir_Change_Out(dir),
      .Wrap_Count_Out(wrap), .Error_Out(err));

   up_down_count_monitor #(.WIDTH(4), .WRAP_WIDTH(2)) dut_sat (
      .Clk_In(clk), .Reset_In(rst2), .Enable_In(en2), .Count_In(cnt2), .Clear_Error_In(clr2),
      .Running_Out(running2), .Up_Downb_Out(updown2), .Dir_Change_Out(dir2),
      .Wrap_Count_Out(wrap2), .Error_Out(err2));

   function automatic void model_reset();
      m_sync = 0; m_prev = 4'd0; m_run = 0; m_up = 1; m_dir = 0; m_wrap = 8'd0; m_err = 0;
   endfunction

   // Drives one sample, predicts the post-edge outputs, and returns 1 ns after the edge.
   task automatic drive(input logic e, input logic [3:0] c, input logic cl);
      int  d;
      bit  bad;
      bit  go_up;
      @(negedge clk);
      en = e; cnt = c; clr = cl;
      m_run = 0; m_dir = 0; bad = 0;
      if (!e) m_sync = 0;
      else if (!m_sync) begin
         m_sync = 1;
         m_prev = c;
      end else begin
         d = (int'(c) - int'(m_prev) + 16) % 16;
         if (d == 1 || d == 15) begin
            go_up = (d == 1);
            m_dir = (go_up != m_up);
            m_up  = go_up;
            m_run = 1;
            if (((go_up && c == 4'd0) || (!go_up && c == 4'd15)) && m_wrap != 8'd255) m_wrap = m_wrap + 8'd1;
         end else if (d != 0) bad = 1;
         m_prev = c;
      end
      m_err = bad ? 1'b1 : (cl ? 1'b0 : m_err);
      exp_q.push_back({m_run, m_up, m_dir, m_wrap, m_err});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; en = 0; clr = 0; cnt = 4'd0;
      rst2 = 1; en2 = 0; clr2 = 0; cnt2 = 4'd0;
      model_reset();
      #1;
      n_checks++;
      if ({running, updown, dir, wrap, err} !== 12'b0_1_0_00000000_0) begin
         n_fail++;
         $display("FAIL reset_state: got %b required %b", {running, updown, dir, wrap, err}, 12'b0_1_0_00000000_0);
      end
      @(negedge clk);
      rst = 0; rst2 = 0;
   endtask

   task automatic test_count_up();
      for (int i = 0; i < 18; i++) begin
         drive(1'b1, 4'(i % 16), 1'b0);
         got = {running, updown, dir, wrap, err};
         expv = exp_q.pop_front();
         n_checks++;
         if (got !== expv) begin
            n_fail++;
            $display("FAIL count_up step %0d: got %b required %b", i, got, expv);
         end
      end
      n_checks++;
      if (wrap !== 8'd1) begin
         n_fail++;
         $display("FAIL count_up_wrap: got %0d required 1", wrap);
      end
   endtask

   task automatic test_count_down();
      logic [3:0] seq [6] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd15, 4'd14};
      drive(1'b0, 4'd3, 1'b0);
      void'(exp_q.pop_front());
      foreach (seq[i]) begin
         drive(1'b1, seq[i], 1'b0);
         got = {running, updown, dir, wrap, err};
         expv = exp_q.pop_front();
         n_checks++;
         if (got !== expv) begin
            n_fail++;
            $display("FAIL count_down step %0d: got %b required %b", i, got, expv);
         end
         if (i == 1) begin
            n_checks++;
            if (dir !== 1'b1 || updown !== 1'b0) begin
               n_fail++;
               $display("FAIL reversal_pulse: got dir=%b up=%b required dir=1 up=0", dir, updown);
            end
         end
      end
      n_checks++;
      if (wrap !== 8'd2 || dir !== 1'b0) begin
         n_fail++;
         $display("FAIL down_wrap: got wrap=%0d dir=%b required wrap=2 dir=0", wrap, dir);
      end
   endtask

   task automatic test_hold();
      logic [3:0] seq [4] = '{4'd5, 4'd5, 4'd5, 4'd6};
      drive(1'b0, 4'd5, 1'b0);
      void'(exp_q.pop_front());
      foreach (seq[i]) begin
         drive(1'b1, seq[i], 1'b0);
         got = {running, updown, dir, wrap, err};
         expv = exp_q.pop_front();
         n_checks++;
         if (got !== expv) begin
            n_fail++;
            $display("FAIL hold step %0d: got %b required %b", i, got, expv);
         end
         if (i == 2) begin
            n_checks++;
            if (running !== 1'b0 || updown !== 1'b0 || err !== 1'b0) begin
               n_fail++;
               $display("FAIL hold_idle: got run=%b up=%b err=%b required 0 0 0", running, updown, err);
            end
         end
      end
   endtask

   task automatic test_error();
      logic [3:0] cs [7] = '{4'd3, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd15};
      logic       cl [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic       ex [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      drive(1'b0, 4'd3, 1'b0);
      void'(exp_q.pop_front());
      foreach (cs[i]) begin
         drive(1'b1, cs[i], cl[i]);
         got = {running, updown, dir, wrap, err};
         expv = exp_q.pop_front();
         n_checks++;
         if (got !== expv) begin
            n_fail++;
            $display("FAIL error step %0d: got %b required %b", i, got, expv);
         end
         n_checks++;
         if (err !== ex[i]) begin
            n_fail++;
            $display("FAIL error_flag step %0d: got %b required %b", i, err, ex[i]);
         end
      end
   endtask

   task automatic test_disable();
      logic       es [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [3:0] cs [5] = '{4'd4, 4'd4, 4'd9, 4'd9, 4'd10};
      foreach (es[i]) begin
         drive(es[i], cs[i], 1'b1);
         got = {running, updown, dir, wrap, err};
         expv = exp_q.pop_front();
         n_checks++;
         if (got !== expv) begin
            n_fail++;
            $display("FAIL disable step %0d: got %b required %b", i, got, expv);
         end
      end
      n_checks++;
      if (running !== 1'b1 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL resync: got run=%b err=%b required run=1 err=0", running, err);
      end
   endtask

   task automatic test_async_reset();
      drive(1'b1, 4'd14, 1'b0);
      void'(exp_q.pop_front());
      drive(1'b1, 4'd3, 1'b0);
      void'(exp_q.pop_front());
      drive(1'b1, 4'd4, 1'b0);
      void'(exp_q.pop_front());
      n_checks++;
      if (err !== 1'b1 || wrap !== 8'd2 || running !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset: got err=%b wrap=%0d run=%b required 1 2 1", err, wrap, running);
      end
      #2;
      rst = 1; en = 0;
      #1;
      n_checks++;
      if ({running, updown, dir, wrap, err} !== 12'b0_1_0_00000000_0) begin
         n_fail++;
         $display("FAIL async_reset: got %b required %b", {running, updown, dir, wrap, err}, 12'b0_1_0_00000000_0);
      end
      model_reset();
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'(7 + i), 1'b0);
         got = {running, updown, dir, wrap, err};
         expv = exp_q.pop_front();
         n_checks++;
         if (got !== expv) begin
            n_fail++;
            $display("FAIL post_reset step %0d: got %b required %b", i, got, expv);
         end
      end
   endtask

   task automatic test_wrap_saturation();
      int wraps = 0;
      @(negedge clk);
      en2 = 1;
      for (int i = 0; i < 81; i++) begin
         cnt2 = 4'(i % 16);
         @(posedge clk);
         #1;
         if (i > 0 && i % 16 == 0) begin
            wraps++;
            n_checks++;
            if (wrap2 !== 2'((wraps > 3) ? 3 : wraps)) begin
               n_fail++;
               $display("FAIL wrap_saturation wrap %0d: got %0d required %0d", wraps, wrap2, (wraps > 3) ? 3 : wraps);
            end
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_count_down();
      test_hold();
      test_error();
      test_disable();
      test_async_reset();
      test_wrap_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
